// File: rtl/nn_pkg.sv
// Shared types and helpers for the time-multiplexed fully-connected layer.
package nn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    POST  = 2'd3
  } state_t;

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Accumulator must hold N_IN full-width products without overflow.
  function automatic bit acc_w_ok(input int acc_w, input int data_w,
                                  input int wgt_w, input int n_in);
    return acc_w >= data_w + wgt_w + $clog2(n_in);
  endfunction

  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v,
                                                    input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/nn_mac_lane.sv
// One neuron: signed MAC accumulator followed by shift, bias, optional ReLU and saturation.
module nn_mac_lane
  import nn_pkg::*;
#(
  parameter int DATA_W  = 9,
  parameter int WGT_W   = 9,
  parameter int FRAC_W  = 4,
  parameter int ACC_W   = 24,
  parameter int RELU_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              acc_en,
  input  logic              load,
  input  logic [DATA_W-1:0] x,
  input  logic [WGT_W-1:0]  w,
  input  logic [DATA_W-1:0] bias,
  output logic [DATA_W-1:0] out
);

  localparam int PROD_W = DATA_W + WGT_W;

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  shifted;
  logic signed [ACC_W:0]    sum;
  logic [DATA_W-1:0]        result;

  assign prod    = $signed(x) * $signed(w);
  assign shifted = acc >>> FRAC_W;

  // One extra bit so adding the bias can never wrap before saturation.
  always_comb begin
    sum = (ACC_W + 1)'(shifted) + (ACC_W + 1)'($signed(bias));
    if (RELU_EN != 0 && sum < 0) sum = '0;
    result = DATA_W'(sat_signed(64'(sum), DATA_W));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      out <= '0;
    end else begin
      if (clr)         acc <= '0;
      else if (acc_en) acc <= acc + ACC_W'(prod);
      if (load)        out <= result;
    end
  end

endmodule

// File: rtl/nn_layer_seq.sv
// Fully-connected layer: N_OUT lanes in parallel, stepping through N_IN inputs one per clock
// with weight rows fetched from an external 1-cycle-latency memory.
module nn_layer_seq
  import nn_pkg::*;
#(
  parameter int N_IN    = 9,
  parameter int N_OUT   = 9,
  parameter int DATA_W  = 9,
  parameter int WGT_W   = 9,
  parameter int FRAC_W  = 4,
  parameter int ACC_W   = 24,
  parameter int RELU_EN = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [N_IN*DATA_W-1:0]         inputs,
  input  logic [N_OUT*DATA_W-1:0]        bias,
  output logic [clog2_min1(N_IN)-1:0]    wgt_addr,
  input  logic [N_OUT*WGT_W-1:0]         wgt_data,
  output logic [N_OUT*DATA_W-1:0]        out,
  output logic                           busy,
  output logic                           done
);

  localparam int ADDR_W = clog2_min1(N_IN);

  if (!acc_w_ok(ACC_W, DATA_W, WGT_W, N_IN)) begin : g_acc_w_illegal
    $error("nn_layer_seq: ACC_W too small for DATA_W+WGT_W+clog2(N_IN)");
  end

  state_t                  state;
  state_t                  state_nxt;
  logic [ADDR_W-1:0]       cnt;
  logic [ADDR_W-1:0]       idx_d;
  logic                    vld_d;
  logic [N_IN*DATA_W-1:0]  in_q;
  logic [N_OUT*DATA_W-1:0] bias_q;
  logic                    accept;
  logic                    load;
  logic                    last;
  logic [DATA_W-1:0]       x;

  assign last     = (cnt == ADDR_W'(N_IN - 1));
  assign busy     = (state != IDLE);
  assign wgt_addr = (state == RUN) ? cnt : '0;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    load      = 1'b0;
    case (state)
      IDLE: if (start) begin
        accept    = 1'b1;
        state_nxt = RUN;
      end
      RUN:   if (last) state_nxt = DRAIN;
      DRAIN: state_nxt = POST;
      POST: begin
        load      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // vld_d/idx_d trail the address by one cycle to line up with the memory read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      idx_d  <= '0;
      vld_d  <= 1'b0;
      in_q   <= '0;
      bias_q <= '0;
      done   <= 1'b0;
    end else begin
      done  <= load;
      vld_d <= (state == RUN);
      idx_d <= cnt;
      if (accept) begin
        in_q   <= inputs;
        bias_q <= bias;
        cnt    <= '0;
      end else if (state == RUN) begin
        cnt <= last ? '0 : cnt + ADDR_W'(1);
      end
    end
  end

  always_comb begin
    x = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (idx_d == ADDR_W'(i)) x = in_q[i*DATA_W +: DATA_W];
    end
  end

  for (genvar j = 0; j < N_OUT; j++) begin : g_lane
    nn_mac_lane #(
      .DATA_W (DATA_W),
      .WGT_W  (WGT_W),
      .FRAC_W (FRAC_W),
      .ACC_W  (ACC_W),
      .RELU_EN(RELU_EN)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .clr   (accept),
      .acc_en(vld_d),
      .load  (load),
      .x     (x),
      .w     (wgt_data[j*WGT_W +: WGT_W]),
      .bias  (bias_q[j*DATA_W +: DATA_W]),
      .out   (out[j*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_nn_layer_seq.sv
// Bench for nn_layer_seq: a ReLU and a non-ReLU instance share stimulus; results are
// checked against an integer-arithmetic model of the layer.
module tb_nn_layer_seq;

  localparam int N_IN   = 9;
  localparam int N_OUT  = 9;
  localparam int DATA_W = 9;
  localparam int WGT_W  = 9;
  localparam int FRAC_W = 4;
  localparam int ACC_W  = 24;
  localparam int AW     = 4;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic [N_IN*DATA_W-1:0]  inputs;
  logic [N_OUT*DATA_W-1:0] bias;
  logic [AW-1:0]           addr_r, addr_n;
  logic [N_OUT*WGT_W-1:0]  wd_r, wd_n;
  logic [N_OUT*DATA_W-1:0] out_r, out_n;
  logic                    busy_r, busy_n, done_r, done_n;

  int wmem [N_IN][N_OUT];
  int in_v [N_IN];
  int bias_v [N_OUT];
  int exp_in [N_IN];
  int exp_bias [N_OUT];
  int n_checks = 0;
  int n_fail = 0;
  int k;
  int extra;

  always #5 clk = ~clk;

  nn_layer_seq #(.N_IN(N_IN), .N_OUT(N_OUT), .DATA_W(DATA_W), .WGT_W(WGT_W),
                 .FRAC_W(FRAC_W), .ACC_W(ACC_W), .RELU_EN(1)) dut_r (
    .clk(clk), .rst(rst), .start(start), .inputs(inputs), .bias(bias),
    .wgt_addr(addr_r), .wgt_data(wd_r), .out(out_r), .busy(busy_r), .done(done_r));

  nn_layer_seq #(.N_IN(N_IN), .N_OUT(N_OUT), .DATA_W(DATA_W), .WGT_W(WGT_W),
                 .FRAC_W(FRAC_W), .ACC_W(ACC_W), .RELU_EN(0)) dut_n (
    .clk(clk), .rst(rst), .start(start), .inputs(inputs), .bias(bias),
    .wgt_addr(addr_n), .wgt_data(wd_n), .out(out_n), .busy(busy_n), .done(done_n));

  // Weight memory with one cycle of read latency.
  always @(posedge clk) begin
    for (int j = 0; j < N_OUT; j++) begin
      wd_r[j*WGT_W +: WGT_W] <= (int'(addr_r) < N_IN) ? WGT_W'(wmem[int'(addr_r)][j]) : '0;
      wd_n[j*WGT_W +: WGT_W] <= (int'(addr_n) < N_IN) ? WGT_W'(wmem[int'(addr_n)][j]) : '0;
    end
  end

  function automatic int model(input int j, input bit relu);
    int acc;
    int r;
    acc = 0;
    for (int i = 0; i < N_IN; i++) acc += exp_in[i] * wmem[i][j];
    r = (acc >>> FRAC_W) + exp_bias[j];
    if (relu && r < 0) r = 0;
    if (r > 255) r = 255;
    if (r < -256) r = -256;
    return r;
  endfunction

  function automatic logic signed [31:0] lane(input logic [N_OUT*DATA_W-1:0] v, input int j);
    logic signed [DATA_W-1:0] t;
    t = v[j*DATA_W +: DATA_W];
    return 32'(t);
  endfunction

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N_IN; i++)  inputs[i*DATA_W +: DATA_W] = DATA_W'(in_v[i]);
    for (int j = 0; j < N_OUT; j++) bias[j*DATA_W +: DATA_W]   = DATA_W'(bias_v[j]);
  endtask

  task automatic scramble();
    for (int i = 0; i < N_IN; i++)  in_v[i]   = int'($urandom_range(511)) - 256;
    for (int j = 0; j < N_OUT; j++) bias_v[j] = int'($urandom_range(511)) - 256;
    drive();
  endtask

  task automatic set_all(input int iv, input int wv, input int bv);
    for (int i = 0; i < N_IN; i++) begin
      in_v[i] = iv;
      for (int j = 0; j < N_OUT; j++) wmem[i][j] = wv;
    end
    for (int j = 0; j < N_OUT; j++) bias_v[j] = bv;
    drive();
  endtask

  task automatic check_outs();
    for (int j = 0; j < N_OUT; j++) begin
      check($sformatf("out_relu[%0d]", j), lane(out_r, j), model(j, 1'b1));
      check($sformatf("out_norelu[%0d]", j), lane(out_n, j), model(j, 1'b0));
    end
  endtask

  // Called just after the capture edge T; returns at the negedge where done is seen.
  // Done is registered at edge T+11 and so occupies the 12th cycle after the start edge.
  task automatic wait_job(input bit pulse5, output int kk);
    logic [N_OUT*DATA_W-1:0] hold_r;
    logic [N_OUT*DATA_W-1:0] hold_n;
    hold_r = out_r;
    hold_n = out_n;
    kk = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 0) check("busy_run", busy_r, 1);
      if (c < N_IN) check("wgt_addr", addr_r, c);
      else if (c == N_IN) check("wgt_addr_drain", addr_r, 0);
      if (pulse5 && c == 4) start = 1'b1;
      if (pulse5 && c == 5) start = 1'b0;
      if (done_r) begin
        kk = c;
        break;
      end
      check("out_hold", (out_r === hold_r) && (out_n === hold_n), 1);
      @(posedge clk);
    end
    check("latency", kk, N_IN + 2);
    check("done_norelu", done_n, 1);
    check("busy_done", busy_r, 0);
  endtask

  task automatic run_job(input bit chained, input bit hold, input bit pulse5);
    if (!chained) begin
      @(negedge clk);
      start = 1'b1;
    end
    @(posedge clk);
    exp_in   = in_v;
    exp_bias = bias_v;
    #1;
    if (!hold) start = 1'b0;
    scramble();
    wait_job(pulse5, k);
    check_outs();
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    inputs = '0;
    bias   = '0;
    set_all(0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_out", (out_r === '0) && (out_n === '0), 1);
    check("rst_done", done_r, 0);
    check("rst_busy", busy_r, 0);
    check("rst_addr", addr_r, 0);

    set_all(16, 16, 0);
    run_job(1'b0, 1'b0, 1'b0);
    check("unity_lane0", lane(out_r, 0), 144);

    set_all(255, 255, 0);
    run_job(1'b0, 1'b0, 1'b0);
    set_all(255, -256, 0);
    run_job(1'b0, 1'b0, 1'b0);
    check("sat_neg_norelu", lane(out_n, 8), -256);

    set_all(16, -16, 0);
    run_job(1'b0, 1'b0, 1'b0);
    check("relu_norelu_lane3", lane(out_n, 3), -144);

    for (int i = 0; i < N_IN; i++) begin
      in_v[i] = (i == 2) ? 16 : 0;
      for (int j = 0; j < N_OUT; j++) wmem[i][j] = j;
    end
    for (int j = 0; j < N_OUT; j++) bias_v[j] = j - 4;
    drive();
    run_job(1'b0, 1'b0, 1'b0);
    check("lane_sep_lane8", lane(out_r, 8), 12);

    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < N_IN; i++)
        for (int j = 0; j < N_OUT; j++)
          wmem[i][j] = (t < 3) ? int'($urandom_range(63)) - 32 : int'($urandom_range(511)) - 256;
      scramble();
      run_job(1'b0, 1'b0, t == 2);
      if (t == 2) begin
        extra = 0;
        repeat (14) begin
          @(negedge clk);
          if (done_r) extra = 1;
        end
        check("ignored_start_no_done", extra, 0);
      end
    end

    // Start held high: each following job is accepted on the previous done cycle.
    scramble();
    run_job(1'b0, 1'b1, 1'b0);
    run_job(1'b1, 1'b1, 1'b0);
    run_job(1'b1, 1'b1, 1'b0);
    start = 1'b0;

    set_all(16, 16, 0);
    run_job(1'b0, 1'b0, 1'b0);
    set_all(20, 30, 5);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_out", (out_r === '0) && (out_n === '0), 1);
    check("midrst_busy", busy_r, 0);
    check("midrst_addr", addr_r, 0);
    check("midrst_done", done_r, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (done_r || busy_r) extra = 1;
    end
    check("midrst_no_done", extra, 0);
    set_all(20, 30, 5);
    run_job(1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nn_layer_seq.md
Name: nn_layer_seq

Overview:
- Parametrised, time-multiplexed fully-connected layer: N_OUT neurons computed in parallel, iterating over N_IN inputs one per clock.
- Replaces per-neuron hard-wired instances. Each network layer becomes one instance, chained by connecting one layer's done to the next layer's start.
- Weights come from an external synchronous ROM/RAM, one row per input index. Bias, fixed-point rescale, saturation and optional ReLU are applied in-block.

Parameters:
- N_IN, 9, inputs per neuron (>=1)
- N_OUT, 9, neurons in the layer (>=1)
- DATA_W, 9, signed input/output width
- WGT_W, 9, signed weight width
- FRAC_W, 4, fractional bits of weights; product is arithmetically shifted right by this amount
- ACC_W, 24, signed accumulator width; elaboration error if < DATA_W+WGT_W+$clog2(N_IN)
- RELU_EN, 1, 1 = clamp negative results to 0

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- inputs  in  N_IN*DATA_W  signed activations; input i at [i*DATA_W +: DATA_W]
- bias  in  N_OUT*DATA_W  signed per-neuron bias; captured with inputs
- wgt_addr  out  max(1,$clog2(N_IN))  weight row index
- wgt_data  in  N_OUT*WGT_W  row wgt_addr, valid one cycle after address; neuron j at [j*WGT_W +: WGT_W]
- out  out  N_OUT*DATA_W  signed results; held until next done
- busy  out  1  high from cycle after accepted start through DRAIN/POST
- done  out  1  one-cycle pulse; out valid from the same cycle

Behaviour:
- Reset: state IDLE; out=0, done=0, busy=0, wgt_addr=0; accumulators, counter and captured inputs/bias cleared. Reset mid-operation aborts immediately with no done pulse.
- States: IDLE -> RUN -> DRAIN -> POST -> IDLE.
- IDLE: on start at edge T, capture inputs and bias, clear all accumulators, cnt=0, go to RUN. done is held low in IDLE except during the pulse cycle.
- RUN (cycles T+1..T+N_IN):
  - wgt_addr=cnt; cnt increments each cycle.
  - A 1-cycle delayed valid/index tag accompanies each address.
  - After cnt==N_IN-1, go to DRAIN.
- Accumulate: on each cycle with the delayed tag valid (T+2..T+N_IN+1), acc_j += sext(inputs[idx]*wgt_data_j). The product is the full signed DATA_W+WGT_W value.
- DRAIN (T+N_IN+1): final accumulate; go to POST.
- POST (T+N_IN+2):
  - r_j = (acc_j >>> FRAC_W) + sext(bias_j).
  - If RELU_EN and r_j<0, r_j=0.
  - Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - Register out and assert done at that edge, then go to IDLE.
- Latency: done high in cycle T+N_IN+3. Accepted start to done is N_IN+3 cycles; throughput is one job per N_IN+3 cycles.
- start while busy: ignored, not queued.
- start in the done cycle: accepted, since the block is in IDLE. Back-to-back jobs have no bubble beyond the done cycle.
- inputs and bias may change after capture without effect on the running job.
- wgt_addr returns to 0 outside RUN.
- N_IN=1: RUN lasts one cycle; the counter is 1 bit wide and does not wrap.
- Shift truncates toward -inf, with no rounding.

Decomposition:
- Package nn_pkg holds:
  - state enum (IDLE, RUN, DRAIN, POST)
  - sat_signed function
  - clog2-with-min-1 helper
  - ACC_W legality check macro/function
- Sub-module nn_mac_lane holds one neuron's accumulator plus bias/shift/ReLU/saturate. It is instantiated N_OUT times by generate.
- The FSM, counter, input capture and address/valid pipe stay in the top module.

Test Plan (defaults; bench ROM model has 1-cycle read latency):
- Reset: assert rst 3 cycles mid-RUN -> next cycle out=0, done=0, busy=0, wgt_addr=0. No done follows. A subsequent start completes correctly.
- Unity: all inputs 16, all weights 16, bias 0. acc=9*256=2304, >>4=144, so every out_j=144. done exactly 12 cycles after start is sampled. wgt_addr sequence is 0..8.
- Saturation: inputs 255, weights 255 -> acc 585225 -> out_j=255. With inputs 255, weights -256, RELU_EN=0 -> out_j=-256.
- ReLU: inputs 16, weights -16, bias 0 -> out_j=0 with RELU_EN=1; out_j=-144 with RELU_EN=0.
- Lane/index separation: weight[i][j]=j, input i=16*(i==2), bias_j=j-4, RELU_EN=1 -> out_j = j + (j-4) = max(2j-4,0), giving 0,0,0,2,4,...,12.
- Handshake: start held high continuously -> jobs start every 12 cycles, each on the done cycle. A start pulse at T+5 during busy is ignored; out changes only at done edges.
